// File: rtl/rot_issue_buffer.sv
// rot_issue_buffer: valid/ready shell around a fixed-latency, non-stallable rotate
// pipeline. Requests go straight to the shifter. A delay line tracks each request's
// valid bit and tag. Results land in an output FIFO. Issue is credit-limited so that
// every accepted request is guaranteed a FIFO slot when its result arrives.
module rot_issue_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 4,
  localparam int SA_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SA_W-1:0]       in_amount,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic [DATA_WIDTH-1:0] sh_data_in,
  output logic [SA_W-1:0]       sh_shift_amount,
  input  logic [DATA_WIDTH-1:0] sh_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [CNT_W-1:0]      in_flight
);

  // A shifter with zero stages still needs one tracking stage.
  localparam int L     = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic                  r_vld [L];
  logic [TAG_WIDTH-1:0]  r_tag [L];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  r_mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_in_flight;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_valid;
  logic [CNT_W:0]        w_credits_used;

  // Credits come from registers only, so in_ready never depends on out_ready/in_valid.
  assign w_credits_used = {1'b0, r_count} + {1'b0, r_in_flight};
  assign in_ready       = w_credits_used < (CNT_W + 1)'(FIFO_DEPTH);

  assign w_accept    = in_valid && in_ready;
  assign w_push      = r_vld[L-1];
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && out_ready;

  // The shifter samples every edge; only accepted requests are tracked below.
  assign sh_data_in      = in_data;
  assign sh_shift_amount = in_amount;

  assign out_valid  = w_out_valid;
  assign out_data   = r_mem_data[r_rd_ptr];
  assign out_tag    = r_mem_tag[r_rd_ptr];
  assign fifo_count = r_count;
  assign in_flight  = r_in_flight;

  // Delay line: stage L-1 valid means sh_data_out currently holds that request's result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_accept;
      r_tag[0] <= in_tag;
      for (int i = 1; i < L; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Output FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= sh_data_out;
        r_mem_tag[r_wr_ptr]  <= r_tag[L-1];
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy and in-flight counters; simultaneous inc/dec cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_in_flight <= '0;
    end else begin
      r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_in_flight <= r_in_flight + CNT_W'(w_accept) - CNT_W'(w_push);
    end
  end

  // Credit scheme guarantees a free slot for every arriving result.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

  // Outstanding work never exceeds the FIFO capacity.
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    w_credits_used <= (CNT_W + 1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_rot_issue_buffer.sv
// Testbench for rot_issue_buffer: behavioural 2-stage rotate pipelines feed two DUTs
// (FIFO depth 4 and 2); a queue scoreboard per DUT checks every popped result.
`timescale 1ns/1ps
module tb_rot_issue_buffer;
  localparam int DW = 8, NS = 2, TW = 4, SAW = 3, CW = 3, CW2 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0, in_valid2 = 1'b0, out_ready = 1'b0;
  logic [DW-1:0]  in_data = '0, exp_data = '0;
  logic [SAW-1:0] in_amount = '0;
  logic [TW-1:0]  in_tag = '0;
  logic           in_ready, in_ready2, out_valid, out_valid2;
  logic [DW-1:0]  sh_data_in, sh_data_out, out_data, sh_data_in2, sh_data_out2, out_data2;
  logic [SAW-1:0] sh_shift_amount, sh_shift_amount2;
  logic [TW-1:0]  out_tag, out_tag2;
  logic [CW-1:0]  fifo_count, in_flight;
  logic [CW2-1:0] fifo_count2, in_flight2;

  rot_issue_buffer #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .FIFO_DEPTH(4), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amount(in_amount), .in_tag(in_tag),
    .sh_data_in(sh_data_in), .sh_shift_amount(sh_shift_amount), .sh_data_out(sh_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .fifo_count(fifo_count), .in_flight(in_flight));

  rot_issue_buffer #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .FIFO_DEPTH(2), .TAG_WIDTH(TW)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_amount(in_amount), .in_tag(in_tag),
    .sh_data_in(sh_data_in2), .sh_shift_amount(sh_shift_amount2), .sh_data_out(sh_data_out2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_tag(out_tag2),
    .fifo_count(fifo_count2), .in_flight(in_flight2));

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d, input logic [SAW-1:0] a);
    logic [2*DW-1:0] t;
    t = {d, d} << a;
    return t[2*DW-1:DW];
  endfunction

  // Behavioural NS-stage rotate pipelines sharing reset_n with the DUTs.
  logic [DW-1:0] pipe1 [NS];
  logic [DW-1:0] pipe2 [NS];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        pipe1[i] <= '0;
        pipe2[i] <= '0;
      end
    end else begin
      pipe1[0] <= rotl(sh_data_in, sh_shift_amount);
      pipe2[0] <= rotl(sh_data_in2, sh_shift_amount2);
      for (int i = 1; i < NS; i++) begin
        pipe1[i] <= pipe1[i-1];
        pipe2[i] <= pipe2[i-1];
      end
    end
  end
  assign sh_data_out  = pipe1[NS-1];
  assign sh_data_out2 = pipe2[NS-1];

  int total = 0, bad = 0;
  int n_acc1 = 0, n_out1 = 0, n_acc2 = 0, n_out2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed { logic [DW-1:0] d; logic [TW-1:0] t; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  // Scoreboards: sampled on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL sb1_extra: got data %0h tag %0h expected no result", out_data, out_tag);
        end else begin
          e = q1.pop_front();
          $display("out1 tag=%0h data=%02h", out_tag, out_data);
          check("sb1_data", 32'(out_data), 32'(e.d));
          check("sb1_tag", 32'(out_tag), 32'(e.t));
        end
        n_out1++;
      end
      if (in_valid && in_ready) begin
        q1.push_back({exp_data, in_tag});
        n_acc1++;
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) begin
          total++; bad++;
          $display("FAIL sb2_extra: got data %0h tag %0h expected no result", out_data2, out_tag2);
        end else begin
          e = q2.pop_front();
          $display("out2 tag=%0h data=%02h", out_tag2, out_data2);
          check("sb2_data", 32'(out_data2), 32'(e.d));
          check("sb2_tag", 32'(out_tag2), 32'(e.t));
        end
        n_out2++;
      end
      if (in_valid2 && in_ready2) begin
        q2.push_back({exp_data, in_tag});
        n_acc2++;
      end
    end
  end

  task automatic drain(input string name);
    int g = 0;
    while ((q1.size() != 0 || q2.size() != 0) && g < 50) begin
      tick();
      g++;
    end
    check(name, 32'(q1.size() + q2.size()), 32'd0);
  endtask

  task automatic set_req(input logic [DW-1:0] d, input logic [SAW-1:0] a, input logic [TW-1:0] t);
    in_data   = d;
    in_amount = a;
    in_tag    = t;
    exp_data  = rotl(d, a);
  endtask

  typedef struct { logic [DW-1:0] d; logic [SAW-1:0] a; logic [TW-1:0] t; logic [DW-1:0] e; } vec_t;
  vec_t vecs [5];

  initial begin
    int a0, o0, run, maxrun, drops, g;
    vecs[0] = '{8'h81, 3'd1, 4'd3, 8'h03};
    vecs[1] = '{8'h01, 3'd7, 4'd1, 8'h80};
    vecs[2] = '{8'hA5, 3'd0, 4'd2, 8'hA5};
    vecs[3] = '{8'hF0, 3'd4, 4'd4, 8'h0F};
    vecs[4] = '{8'h5A, 3'd3, 4'd5, 8'hD2};

    // Values held during reset.
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_in_flight", 32'(in_flight), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Table vectors: one request at a time, latency and result checked directly.
    for (int i = 0; i < 5; i++) begin
      in_data = vecs[i].d; in_amount = vecs[i].a; in_tag = vecs[i].t; exp_data = vecs[i].e;
      in_valid = 1'b1;
      check("vec_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("vec_in_flight", 32'(in_flight), 32'd1);
      check("vec_lat_k1", 32'(out_valid), 32'd0);
      tick();
      check("vec_lat_k2", 32'(out_valid), 32'd0);
      tick();
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_count", 32'(fifo_count), 32'd1);
      check("vec_data", 32'(out_data), 32'(vecs[i].e));
      check("vec_tag", 32'(out_tag), 32'(vecs[i].t));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("vec_popped", 32'(out_valid), 32'd0);
    end

    // Backpressure: six requests offered, only four credits available.
    a0 = n_acc1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(8'h13 * DW'(i + 1), SAW'(i + 1), TW'(8 + i));
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(n_acc1 - a0), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_in_flight", 32'(in_flight), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'(rotl(8'h13, 3'd1)));
    tick();
    check("bp_hold_stable", 32'(out_data), 32'(rotl(8'h13, 3'd1)));
    check("bp_still_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_count_after_pop", 32'(fifo_count), 32'd3);
    drain("bp_drain");
    check("bp_empty", 32'(out_valid), 32'd0);

    // Push and pop on the same edge at the highest reachable occupancy.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(8'hC1 + DW'(i), SAW'(i), TW'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pp_count_before", 32'(fifo_count), 32'd3);
    check("pp_flight_before", 32'(in_flight), 32'd1);
    out_ready = 1'b1;
    tick();
    check("pp_count_after", 32'(fifo_count), 32'd3);
    check("pp_flight_after", 32'(in_flight), 32'd0);
    check("pp_head_tag", 32'(out_tag), 32'd1);
    drain("pp_drain");

    // Streaming: 16 back-to-back requests with the consumer always ready.
    a0 = n_acc1; run = 0; maxrun = 0; drops = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        set_req(DW'(c * 37 + 5), SAW'(c), TW'(c));
        in_valid = 1'b1;
        if (!in_ready) drops++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) run++;
      else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
    end
    check("st_ready_drops", 32'(drops), 32'd0);
    check("st_accepted", 32'(n_acc1 - a0), 32'd16);
    check("st_consecutive", 32'(maxrun), 32'd16);
    drain("st_drain");

    // Asynchronous reset with work in the FIFO and in the pipeline.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(8'h77 + DW'(i), 3'd2, TW'(i + 10));
      tick();
    end
    in_valid = 1'b0;
    check("mr_count", 32'(fifo_count), 32'd2);
    check("mr_flight", 32'(in_flight), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    q1.delete();
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    check("mr_out_tag", 32'(out_tag), 32'd0);
    check("mr_fifo_count", 32'(fifo_count), 32'd0);
    check("mr_in_flight", 32'(in_flight), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    o0 = n_out1;
    for (int i = 0; i < 4; i++) tick();
    check("mr_no_stale", 32'(n_out1 - o0), 32'd0);
    out_ready = 1'b0;
    in_data = 8'h3C; in_amount = 3'd2; in_tag = 4'd7; exp_data = 8'hF0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 10) begin
      tick();
      g++;
    end
    check("mr_new_valid", 32'(out_valid), 32'd1);
    check("mr_new_data", 32'(out_data), 32'hF0);
    check("mr_new_tag", 32'(out_tag), 32'd7);
    out_ready = 1'b1;
    tick();
    check("mr_new_count", 32'(n_out1 - o0), 32'd1);
    check("mr_empty", 32'(out_valid), 32'd0);

    // Depth-2 instance: same streaming traffic must throttle without loss or reorder.
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      set_req(DW'(i * 53 + 9), SAW'(i + 3), TW'(15 - i));
      in_valid2 = 1'b1;
      g = 0;
      while (!in_ready2 && g < 20) begin
        drops++;
        tick();
        g++;
      end
      tick();
    end
    in_valid2 = 1'b0;
    drain("d2_drain");
    check("d2_accepted", 32'(n_acc2), 32'd16);
    check("d2_results", 32'(n_out2), 32'd16);
    check("d2_throttled", 32'(drops > 0), 32'd1);
    check("d2_count", 32'(fifo_count2), 32'd0);
    check("d2_flight", 32'(in_flight2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
